pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline hazard and memory-stall controller for the 5-stage core. It drives hold/flush controls into the fetch, decode/execute and execute/memory pipeline registers, and forwarding selects into the execute-stage operand muxes. It also sequences the multi-cycle data-memory handshake, freezing the pipeline until the access completes. It sits beside the pipeline registers and is clocked on the same falling edge.

## Interface
Parameters:
- `REG_BITS`, 5: register-index width.
- `TIMEOUT`, 16: maximum BUSY cycles before abort (≥2).
- `CNT_WIDTH`, 16: stall-counter width.

Ports:
- `CLK` in 1: clock; all state updates on the falling edge.
- `CLR` in 1: reset, asynchronous, active-high.
- `RA1_D`, `RA2_D` in REG_BITS: decode-stage source indices.
- `RA1_E`, `RA2_E` in REG_BITS: execute-stage source indices.
- `WRITE_REG_E` in REG_BITS, `REG_WRITE_E` in 1, `MEM_TO_REG_E` in 1: execute-stage destination and controls.
- `WRITE_REG_M` in REG_BITS, `REG_WRITE_M` in 1, `MEM_TO_REG_M` in 1, `MEM_WRITE_M` in 1: memory-stage destination and controls.
- `WRITE_REG_W` in REG_BITS, `REG_WRITE_W` in 1: writeback-stage destination and control.
- `MEM_ACK` in 1: data memory done, sampled on the falling edge.
- `STALL_F`, `STALL_D` out 1: hold PC and fetch/decode register.
- `STALL_E`, `STALL_M` out 1: hold decode/execute and execute/memory registers.
- `FLUSH_E` out 1: drives the decode/execute register clear (bubble insert).
- `FWD_A_E`, `FWD_B_E` out 2: operand select. 00 = register file, 01 = writeback result, 10 = memory-stage ALU result.
- `MEM_REQ` out 1: registered memory request.
- `MEM_ERR` out 1: sticky timeout flag.
- `STALL_CNT` out CNT_WIDTH: saturating count of stalled cycles.

## Operation
- Register 0 is hardwired zero. A destination of 0 never matches for forwarding or load-use.
- Forwarding (combinational, A shown; B identical with RA2_E):
  - 10 if `REG_WRITE_M` and `WRITE_REG_M == RA1_E`.
  - Else 01 if `REG_WRITE_W` and `WRITE_REG_W == RA1_E`.
  - Else 00.
  - The memory stage wins when both match.
- Load-use: `lu = MEM_TO_REG_E & REG_WRITE_E & (WRITE_REG_E == RA1_D | WRITE_REG_E == RA2_D)`, with destination ≠ 0.
- Memory operation in M: `mop = MEM_TO_REG_M | MEM_WRITE_M`.
- Memory FSM states:
  - IDLE: on `mop`, go to BUSY and set `MEM_REQ = 1`.
  - BUSY: on `MEM_ACK`, go to DONE and clear `MEM_REQ`. If the timeout counter reaches TIMEOUT−1 without ack, set `MEM_ERR`, clear `MEM_REQ`, go to DONE.
  - DONE: unconditionally go to IDLE. No stall in this state; the pipeline advances.
- Timeout counter: zeroed on entry to BUSY, increments each BUSY cycle.
- `mstall = (IDLE & mop) | BUSY`.
- When `mstall`: all four STALL outputs are 1 and `FLUSH_E = 0`. The memory stall dominates load-use, so no instruction is lost.
- Else when `lu`: `STALL_F = STALL_D = FLUSH_E = 1`, `STALL_E = STALL_M = 0`.
- `STALL_CNT` increments on every edge where `STALL_F` is high and saturates at all-ones.
- `MEM_ERR` clears only on CLR.

## Timing
- Reset (CLR high, asynchronous): state IDLE, `MEM_REQ = 0`, `MEM_ERR = 0`, `STALL_CNT = 0`, timeout counter 0.
- While CLR is high: `FLUSH_E = 1`, all STALL outputs 0, `FWD_*` are the combinational functions of inputs.
- Forwarding, stall and flush outputs are combinational, valid before the next falling edge. There are no registered delays on hazard detection.
- Memory-access latency: an access entering M before edge n gives `MEM_REQ` high after edge n. With ack sampled at edge n+k (k ≥ 1): DONE after edge n+k, pipeline advances at edge n+k+1. Minimum M occupancy is 3 cycles.
- Back-to-back memory operations: DONE→IDLE coincides with the next op entering M. That op triggers BUSY at the following edge.
- `MEM_ACK` is ignored outside BUSY.
- CLR mid-BUSY: `MEM_REQ` drops immediately and the in-flight access is abandoned.

## Structure
- Shared package `pipe_ctrl_pkg`:
  - `mem_state_t` enum {IDLE, BUSY, DONE}.
  - Forward-select constants `FWD_RF = 2'b00`, `FWD_WB = 2'b01`, `FWD_MEM = 2'b10`.
- Sub-module `pipe_mem_fsm` holds the FSM, timeout counter, `MEM_REQ` and `MEM_ERR`, and outputs `mstall`.
- Forwarding, load-use logic and `STALL_CNT` stay in the top module.

## Test plan
- Forwarding, M priority: `REG_WRITE_M = 1`, `WRITE_REG_M = 3`, `REG_WRITE_W = 1`, `WRITE_REG_W = 3`, `RA1_E = 3` → `FWD_A_E = 10`. Set `WRITE_REG_M = 4` → `FWD_A_E = 01`.
- r0: all destinations 0, `RA1_E = RA2_E = 0` → `FWD_* = 00`. Load in E with dest 0 and `RA1_D = 0` → no stall.
- Load-use: `MEM_TO_REG_E = REG_WRITE_E = 1`, `WRITE_REG_E = 5`, `RA2_D = 5` → `STALL_F = STALL_D = FLUSH_E = 1` for one cycle. `STALL_CNT` goes 0→1.
- Memory handshake: `MEM_WRITE_M = 1`, ack returned 3 cycles after `MEM_REQ` rises → stalls high for 4 cycles, then DONE with stalls low. `STALL_CNT = 4`.
- Timeout: `TIMEOUT = 4`, `MEM_ACK` held 0 → `MEM_ERR = 1` after 4 BUSY cycles, `MEM_REQ = 0`, pipeline released, flag sticky.
- Reset mid-BUSY: assert CLR asynchronously between edges → `MEM_REQ`, `STALL_CNT` and `MEM_ERR` are 0 immediately, state IDLE.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard / memory-stall controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/pipe_mem_fsm.sv
// Data-memory handshake sequencer: request, ack/timeout, one-cycle release.
//   state | meaning
//   IDLE  | no access; a memory op in M stalls and requests at the next edge
//   BUSY  | request outstanding; wait for ack or timeout
//   DONE  | access finished; pipeline advances this cycle
module pipe_mem_fsm
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic clr,
    input  logic mop,
    input  logic mem_ack,
    output logic mem_req,
    output logic mem_err,
    output logic mstall
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    mem_state_t    state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_err_q, mem_err_d;

    always_ff @(negedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= IDLE;
            tmo_q     <= '0;
            mem_req_q <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            mem_req_q <= mem_req_d;
            mem_err_q <= mem_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        mem_req_d = mem_req_q;
        mem_err_d = mem_err_q;
        mstall    = 1'b0;
        case (state_q)
            IDLE: begin
                mstall = mop;
                if (mop) begin
                    state_d   = BUSY;
                    tmo_d     = '0;
                    mem_req_d = 1'b1;
                end
            end
            BUSY: begin
                mstall = 1'b1;
                // ack on the last allowed cycle still counts as success
                if (mem_ack) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                end else if (tmo_q == TMO_LAST) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    mem_err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    assign mem_req = mem_req_q;
    assign mem_err = mem_err_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage core: operand forwarding, load-use bubbles,
// memory-access freeze and a saturating stall counter. Falling-edge clocked.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_BITS  = 5,
    parameter int TIMEOUT   = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 CLR,
    input  logic [REG_BITS-1:0]  RA1_D,
    input  logic [REG_BITS-1:0]  RA2_D,
    input  logic [REG_BITS-1:0]  RA1_E,
    input  logic [REG_BITS-1:0]  RA2_E,
    input  logic [REG_BITS-1:0]  WRITE_REG_E,
    input  logic                 REG_WRITE_E,
    input  logic                 MEM_TO_REG_E,
    input  logic [REG_BITS-1:0]  WRITE_REG_M,
    input  logic                 REG_WRITE_M,
    input  logic                 MEM_TO_REG_M,
    input  logic                 MEM_WRITE_M,
    input  logic [REG_BITS-1:0]  WRITE_REG_W,
    input  logic                 REG_WRITE_W,
    input  logic                 MEM_ACK,
    output logic                 STALL_F,
    output logic                 STALL_D,
    output logic                 STALL_E,
    output logic                 STALL_M,
    output logic                 FLUSH_E,
    output logic [1:0]           FWD_A_E,
    output logic [1:0]           FWD_B_E,
    output logic                 MEM_REQ,
    output logic                 MEM_ERR,
    output logic [CNT_WIDTH-1:0] STALL_CNT
);

    logic                 mop;
    logic                 mstall;
    logic                 lu;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    // r0 is hardwired zero, so a zero destination never produces a hazard
    function automatic logic [1:0] fwd_sel(
        input logic [REG_BITS-1:0] ra,
        input logic [REG_BITS-1:0] wr_m,
        input logic                rw_m,
        input logic [REG_BITS-1:0] wr_w,
        input logic                rw_w
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (rw_m && (wr_m != '0) && (wr_m == ra)) begin
            sel = FWD_MEM;
        end else if (rw_w && (wr_w != '0) && (wr_w == ra)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    assign mop = MEM_TO_REG_M | MEM_WRITE_M;

    pipe_mem_fsm #(
        .TIMEOUT (TIMEOUT)
    ) u_mem_fsm (
        .clk     (CLK),
        .clr     (CLR),
        .mop     (mop),
        .mem_ack (MEM_ACK),
        .mem_req (MEM_REQ),
        .mem_err (MEM_ERR),
        .mstall  (mstall)
    );

    always_comb begin
        lu = MEM_TO_REG_E && REG_WRITE_E && (WRITE_REG_E != '0)
             && ((WRITE_REG_E == RA1_D) || (WRITE_REG_E == RA2_D));
    end

    always_comb begin
        FWD_A_E = fwd_sel(RA1_E, WRITE_REG_M, REG_WRITE_M, WRITE_REG_W, REG_WRITE_W);
        FWD_B_E = fwd_sel(RA2_E, WRITE_REG_M, REG_WRITE_M, WRITE_REG_W, REG_WRITE_W);
        STALL_F = 1'b0;
        STALL_D = 1'b0;
        STALL_E = 1'b0;
        STALL_M = 1'b0;
        FLUSH_E = 1'b0;
        // memory freeze outranks load-use so the waiting load is not bubbled away
        if (CLR) begin
            FLUSH_E = 1'b1;
        end else if (mstall) begin
            STALL_F = 1'b1;
            STALL_D = 1'b1;
            STALL_E = 1'b1;
            STALL_M = 1'b1;
        end else if (lu) begin
            STALL_F = 1'b1;
            STALL_D = 1'b1;
            FLUSH_E = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (STALL_F && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(negedge CLK or posedge CLR) begin
        if (CLR) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign STALL_CNT = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed hazard scenarios followed by
// random traffic, each cycle checked against an abstract reference model.
module tb_pipe_hazard_ctrl;

    localparam int RB      = 5;
    localparam int TMO     = 4;
    localparam int CW      = 6;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          CLK = 1'b0;
    logic          CLR = 1'b1;
    logic [RB-1:0] RA1_D = '0, RA2_D = '0, RA1_E = '0, RA2_E = '0;
    logic [RB-1:0] WRITE_REG_E = '0, WRITE_REG_M = '0, WRITE_REG_W = '0;
    logic          REG_WRITE_E = 1'b0, MEM_TO_REG_E = 1'b0;
    logic          REG_WRITE_M = 1'b0, MEM_TO_REG_M = 1'b0, MEM_WRITE_M = 1'b0;
    logic          REG_WRITE_W = 1'b0, MEM_ACK = 1'b0;
    logic          STALL_F, STALL_D, STALL_E, STALL_M, FLUSH_E;
    logic [1:0]    FWD_A_E, FWD_B_E;
    logic          MEM_REQ, MEM_ERR;
    logic [CW-1:0] STALL_CNT;

    pipe_hazard_ctrl #(
        .REG_BITS  (RB),
        .TIMEOUT   (TMO),
        .CNT_WIDTH (CW)
    ) dut (
        .CLK          (CLK),
        .CLR          (CLR),
        .RA1_D        (RA1_D),
        .RA2_D        (RA2_D),
        .RA1_E        (RA1_E),
        .RA2_E        (RA2_E),
        .WRITE_REG_E  (WRITE_REG_E),
        .REG_WRITE_E  (REG_WRITE_E),
        .MEM_TO_REG_E (MEM_TO_REG_E),
        .WRITE_REG_M  (WRITE_REG_M),
        .REG_WRITE_M  (REG_WRITE_M),
        .MEM_TO_REG_M (MEM_TO_REG_M),
        .MEM_WRITE_M  (MEM_WRITE_M),
        .WRITE_REG_W  (WRITE_REG_W),
        .REG_WRITE_W  (REG_WRITE_W),
        .MEM_ACK      (MEM_ACK),
        .STALL_F      (STALL_F),
        .STALL_D      (STALL_D),
        .STALL_E      (STALL_E),
        .STALL_M      (STALL_M),
        .FLUSH_E      (FLUSH_E),
        .FWD_A_E      (FWD_A_E),
        .FWD_B_E      (FWD_B_E),
        .MEM_REQ      (MEM_REQ),
        .MEM_ERR      (MEM_ERR),
        .STALL_CNT    (STALL_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic          clr;
        logic [RB-1:0] ra1_d, ra2_d, ra1_e, ra2_e;
        logic [RB-1:0] wr_e, wr_m, wr_w;
        logic          rw_e, m2r_e, rw_m, m2r_m, mw_m, rw_w;
        logic          ack;
    } stim_t;

    typedef struct {
        int cyc;
        int fwd_a, fwd_b;
        int sf, sd, se, sm, fl;
        int req, err, cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    // reference model: an outstanding access, its wait count, a release cycle
    bit m_waiting, m_release, m_err;
    int m_waited, m_cnt;

    function automatic stim_t quiet();
        stim_t s;
        s.clr  = 1'b0;
        s.ra1_d = '0; s.ra2_d = '0; s.ra1_e = '0; s.ra2_e = '0;
        s.wr_e = '0; s.wr_m = '0; s.wr_w = '0;
        s.rw_e = 1'b0; s.m2r_e = 1'b0; s.rw_m = 1'b0;
        s.m2r_m = 1'b0; s.mw_m = 1'b0; s.rw_w = 1'b0;
        s.ack  = 1'b0;
        return s;
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        s.clr   = ($urandom_range(0, 199) == 0);
        s.ra1_d = RB'($urandom_range(0, 3));
        s.ra2_d = RB'($urandom_range(0, 3));
        s.ra1_e = RB'($urandom_range(0, 3));
        s.ra2_e = RB'($urandom_range(0, 3));
        s.wr_e  = RB'($urandom_range(0, 3));
        s.wr_m  = RB'($urandom_range(0, 3));
        s.wr_w  = RB'($urandom_range(0, 3));
        s.rw_e  = 1'($urandom_range(0, 1));
        s.m2r_e = 1'($urandom_range(0, 1));
        s.rw_m  = 1'($urandom_range(0, 1));
        s.rw_w  = 1'($urandom_range(0, 1));
        s.m2r_m = ($urandom_range(0, 5) == 0);
        s.mw_m  = ($urandom_range(0, 5) == 0);
        s.ack   = ($urandom_range(0, 2) == 0);
        return s;
    endfunction

    function automatic int ref_fwd(input int ra, input stim_t s);
        if (ra == 0) return 0;
        if (s.rw_m && int'(s.wr_m) == ra) return 2;
        if (s.rw_w && int'(s.wr_w) == ra) return 1;
        return 0;
    endfunction

    task automatic apply(input stim_t s);
        exp_t e;
        bit   mop, frz, lu;
        @(posedge CLK);
        #1;
        CLR = s.clr;
        RA1_D = s.ra1_d; RA2_D = s.ra2_d; RA1_E = s.ra1_e; RA2_E = s.ra2_e;
        WRITE_REG_E = s.wr_e; REG_WRITE_E = s.rw_e; MEM_TO_REG_E = s.m2r_e;
        WRITE_REG_M = s.wr_m; REG_WRITE_M = s.rw_m;
        MEM_TO_REG_M = s.m2r_m; MEM_WRITE_M = s.mw_m;
        WRITE_REG_W = s.wr_w; REG_WRITE_W = s.rw_w;
        MEM_ACK = s.ack;
        cyc++;
        if (s.clr) begin
            m_waiting = 0; m_release = 0; m_err = 0; m_waited = 0; m_cnt = 0;
        end
        mop = s.m2r_m || s.mw_m;
        frz = !s.clr && (m_waiting || (!m_release && mop));
        lu  = !s.clr && s.m2r_e && s.rw_e && (s.wr_e != 0)
              && (s.wr_e == s.ra1_d || s.wr_e == s.ra2_d);
        e.cyc   = cyc;
        e.fwd_a = ref_fwd(int'(s.ra1_e), s);
        e.fwd_b = ref_fwd(int'(s.ra2_e), s);
        e.sf    = int'(frz || lu);
        e.sd    = int'(frz || lu);
        e.se    = int'(frz);
        e.sm    = int'(frz);
        e.fl    = int'(s.clr || (!frz && lu));
        e.req   = int'(m_waiting);
        e.err   = int'(m_err);
        e.cnt   = m_cnt;
        exp_q.push_back(e);
        // state as it will be after the coming falling edge
        if (!s.clr) begin
            if (e.sf == 1 && m_cnt < CNT_MAX) m_cnt++;
            if (m_release) begin
                m_release = 0;
            end else if (m_waiting) begin
                if (s.ack) begin
                    m_waiting = 0; m_release = 1;
                end else if (m_waited + 1 >= TMO) begin
                    m_waiting = 0; m_release = 1; m_err = 1;
                end else begin
                    m_waited++;
                end
            end else if (mop) begin
                m_waiting = 1; m_waited = 0;
            end
        end
    endtask

    task automatic chk(input string name, input int c, input logic [31:0] got, input int want);
        checks++;
        if (got !== 32'(want)) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, c, got, want);
        end
    endtask

    always @(posedge CLK) begin
        exp_t e;
        #4;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("fwd_a",     e.cyc, 32'(FWD_A_E),   e.fwd_a);
            chk("fwd_b",     e.cyc, 32'(FWD_B_E),   e.fwd_b);
            chk("stall_f",   e.cyc, 32'(STALL_F),   e.sf);
            chk("stall_d",   e.cyc, 32'(STALL_D),   e.sd);
            chk("stall_e",   e.cyc, 32'(STALL_E),   e.se);
            chk("stall_m",   e.cyc, 32'(STALL_M),   e.sm);
            chk("flush_e",   e.cyc, 32'(FLUSH_E),   e.fl);
            chk("mem_req",   e.cyc, 32'(MEM_REQ),   e.req);
            chk("mem_err",   e.cyc, 32'(MEM_ERR),   e.err);
            chk("stall_cnt", e.cyc, 32'(STALL_CNT), e.cnt);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        stim_t s;
        s = quiet(); s.clr = 1'b1;
        apply(s); apply(s);

        // forwarding priority: M beats W, then W alone, then operand B
        s = quiet(); s.rw_m = 1; s.wr_m = 3; s.rw_w = 1; s.wr_w = 3; s.ra1_e = 3;
        apply(s);
        s.wr_m = 4; apply(s);
        s.ra2_e = 4; apply(s);

        // r0 never forwards or interlocks
        s = quiet(); s.rw_m = 1; s.rw_w = 1; apply(s);
        s.m2r_e = 1; s.rw_e = 1; s.wr_e = 0; apply(s);

        // load-use bubble for one cycle
        s = quiet(); s.m2r_e = 1; s.rw_e = 1; s.wr_e = 5; s.ra2_d = 5; apply(s);
        s = quiet(); apply(s);

        // store handshake with ack on the third BUSY cycle, stray ack while idle
        s = quiet(); s.clr = 1; apply(s);
        s = quiet(); s.mw_m = 1; apply(s); apply(s); apply(s);
        s.ack = 1; apply(s);
        s.ack = 0; apply(s);
        s = quiet(); s.ack = 1; apply(s);
        s = quiet(); apply(s);

        // back-to-back memory ops and memory stall overriding load-use
        s = quiet(); s.mw_m = 1; apply(s);
        s.ack = 1; apply(s);
        s.ack = 0; apply(s);
        s.m2r_e = 1; s.rw_e = 1; s.wr_e = 2; s.ra1_d = 2; apply(s);
        apply(s);
        s.ack = 1; apply(s);
        s = quiet(); apply(s); apply(s);

        // timeout: ack never arrives, error is sticky
        s = quiet(); s.clr = 1; apply(s);
        s = quiet(); s.m2r_m = 1; s.rw_m = 1; s.wr_m = 7; s.ra1_e = 7;
        for (int i = 0; i < 6; i++) apply(s);
        s = quiet(); apply(s); apply(s);

        // reset asserted mid-access
        s = quiet(); s.mw_m = 1; apply(s); apply(s);
        s.clr = 1; apply(s);
        s = quiet(); apply(s);

        // counter saturation
        s = quiet(); s.m2r_e = 1; s.rw_e = 1; s.wr_e = 9; s.ra1_d = 9;
        for (int i = 0; i < CNT_MAX + 6; i++) apply(s);

        for (int i = 0; i < 3000; i++) apply(rnd());

        @(posedge CLK);
        #6;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain cyc=%0d got=%0d exp=0", cyc, exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
